// File: rtl/uart_cmd_frame_parser.sv
// Parses UART RX frames ('W'/'R' + addr [+ data]) into one-cycle word commands and serialises the reply to UART TX.
// Latency: cmd_valid the cycle after the last frame byte; first tx_valid the cycle after rsp_valid.
// Backpressure: tx_byte/tx_valid hold while tx_ready is low (unbounded); RX bytes outside ADDR/DATA/IDLE are dropped.
module uart_cmd_frame_parser #(
  parameter int BYTE_TIMEOUT = 100000,
  parameter int RSP_TIMEOUT  = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        cmd_valid,
  output logic        cmd_wr_word,
  output logic        cmd_rd_word,
  output logic [15:0] cmd_addr,
  output logic [31:0] cmd_data,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  output logic        busy
);

  localparam int IBW = $clog2(BYTE_TIMEOUT + 1);
  localparam int RSW = $clog2(RSP_TIMEOUT + 1);

  localparam logic [7:0] OP_WR    = 8'h57;
  localparam logic [7:0] OP_RD    = 8'h52;
  localparam logic [7:0] RSP_OK   = 8'h4B;
  localparam logic [7:0] RSP_TOUT = 8'h54;
  localparam logic [7:0] RSP_ERR  = 8'h45;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_ISSUE,
    S_WAIT_RSP,
    S_ERR,
    S_SEND
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [2:0]     byte_cnt;
  logic [IBW-1:0] ib_cnt;
  logic [RSW-1:0] rsp_cnt;
  logic           is_wr;
  logic [31:0]    tx_buf;
  logic [2:0]     tx_len;

  logic ib_expired;
  logic rsp_expired;
  logic tx_fire;
  logic entering;

  // Timeout expiry flags and handshake/entry qualifiers shared by both processes.
  always_comb begin
    ib_expired  = (ib_cnt == IBW'(BYTE_TIMEOUT - 1));
    rsp_expired = (rsp_cnt == RSW'(RSP_TIMEOUT - 1));
    tx_fire     = (state == S_SEND) && tx_ready;
    entering    = (state_next != state);
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and state-derived outputs; timeouts take priority over a coincident rx_valid.
  always_comb begin
    state_next  = state;
    cmd_valid   = 1'b0;
    cmd_wr_word = 1'b0;
    cmd_rd_word = 1'b0;
    tx_valid    = 1'b0;
    tx_byte     = 8'h00;
    busy        = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_byte == OP_WR || rx_byte == OP_RD) begin
            state_next = S_ADDR;
          end else begin
            state_next = S_ERR;
          end
        end
      end
      S_ADDR: begin
        if (ib_expired) begin
          state_next = S_IDLE;
        end else if (rx_valid && byte_cnt == 3'd1) begin
          state_next = is_wr ? S_DATA : S_ISSUE;
        end
      end
      S_DATA: begin
        if (ib_expired) begin
          state_next = S_IDLE;
        end else if (rx_valid && byte_cnt == 3'd3) begin
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cmd_valid   = 1'b1;
        cmd_wr_word = is_wr;
        cmd_rd_word = ~is_wr;
        state_next  = S_WAIT_RSP;
      end
      S_WAIT_RSP: begin
        if (rsp_valid || rsp_expired) begin
          state_next = S_SEND;
        end
      end
      S_ERR: begin
        state_next = S_SEND;
      end
      S_SEND: begin
        tx_valid = 1'b1;
        case (byte_cnt[1:0])
          2'd0:    tx_byte = tx_buf[31:24];
          2'd1:    tx_byte = tx_buf[23:16];
          2'd2:    tx_byte = tx_buf[15:8];
          default: tx_byte = tx_buf[7:0];
        endcase
        if (tx_ready && byte_cnt == tx_len - 3'd1) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: frame shift registers, counters (cleared on every state change) and the reply buffer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      byte_cnt <= '0;
      ib_cnt   <= '0;
      rsp_cnt  <= '0;
      is_wr    <= 1'b0;
      cmd_addr <= '0;
      cmd_data <= '0;
      tx_buf   <= '0;
      tx_len   <= '0;
    end else begin
      if (entering) begin
        byte_cnt <= '0;
      end else if (((state == S_ADDR || state == S_DATA) && rx_valid && !ib_expired) || tx_fire) begin
        byte_cnt <= byte_cnt + 3'd1;
      end

      if (entering || rx_valid || !(state == S_ADDR || state == S_DATA)) begin
        ib_cnt <= '0;
      end else begin
        ib_cnt <= ib_cnt + IBW'(1);
      end

      if (entering) begin
        rsp_cnt <= '0;
      end else if (state == S_WAIT_RSP && !rsp_expired) begin
        rsp_cnt <= rsp_cnt + RSW'(1);
      end

      if (state == S_IDLE && rx_valid) begin
        is_wr <= (rx_byte == OP_WR);
      end

      if (state == S_ADDR && rx_valid && !ib_expired) begin
        cmd_addr <= {cmd_addr[7:0], rx_byte};
      end

      if (state == S_DATA && rx_valid && !ib_expired) begin
        cmd_data <= {cmd_data[23:0], rx_byte};
      end

      if (state == S_WAIT_RSP) begin
        if (rsp_valid) begin
          tx_buf <= is_wr ? {RSP_OK, 24'h0} : rsp_data;
          tx_len <= is_wr ? 3'd1 : 3'd4;
        end else if (rsp_expired) begin
          tx_buf <= {RSP_TOUT, 24'h0};
          tx_len <= 3'd1;
        end
      end else if (state == S_ERR) begin
        tx_buf <= {RSP_ERR, 24'h0};
        tx_len <= 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_frame_parser.sv
// Scoreboard bench for uart_cmd_frame_parser: expected commands/TX bytes queued at stimulus time, compared on output.
// Latency: checks cmd_valid and first tx_valid timing plus both timeout lengths.
// Backpressure: optional tx_ready stall of 10 cycles per byte with hold-stability checks.
module tb_uart_cmd_frame_parser;

  localparam int BT = 40;
  localparam int RT = 20;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        cmd_valid;
  logic        cmd_wr_word;
  logic        cmd_rd_word;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = 32'h0;
  logic        busy;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] data;
  } cmd_t;

  cmd_t       exp_cmd[$];
  logic [7:0] exp_tx[$];

  int checks = 0;
  int errors = 0;
  bit stall_en = 1'b0;

  uart_cmd_frame_parser #(.BYTE_TIMEOUT(BT), .RSP_TIMEOUT(RT)) dut (
    .CLK(CLK), .RST(RST),
    .rx_byte(rx_byte), .rx_valid(rx_valid),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cmd_valid(cmd_valid), .cmd_wr_word(cmd_wr_word), .cmd_rd_word(cmd_rd_word),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Output monitor and tx_ready driver, all at the falling edge.
  initial begin
    bit         held = 1'b0;
    logic [7:0] held_byte = 8'h00;
    int         stall_cnt = 0;
    cmd_t       c;
    logic [7:0] b;
    forever begin
      @(negedge CLK);
      if (RST) begin
        held = 1'b0;
        stall_cnt = 0;
      end else begin
        if (cmd_valid) begin
          check("cmd_onehot", 32'(cmd_wr_word ^ cmd_rd_word), 32'd1);
          if (exp_cmd.size() == 0) begin
            check("cmd_unexpected", 32'(cmd_valid), 32'd0);
          end else begin
            c = exp_cmd.pop_front();
            check("cmd_wr", 32'(cmd_wr_word), 32'(c.wr));
            check("cmd_addr", 32'(cmd_addr), 32'(c.addr));
            if (c.wr) check("cmd_data", cmd_data, c.data);
          end
        end
        if (held) begin
          check("tx_hold_vld", 32'(tx_valid), 32'd1);
          check("tx_hold_byte", 32'(tx_byte), 32'(held_byte));
        end
        if (stall_en) begin
          if (tx_valid) begin
            if (stall_cnt < 10) begin
              tx_ready = 1'b0;
              stall_cnt++;
            end else begin
              tx_ready = 1'b1;
              stall_cnt = 0;
            end
          end else begin
            tx_ready = 1'b0;
            stall_cnt = 0;
          end
        end else begin
          tx_ready = 1'b1;
        end
        if (tx_valid && tx_ready) begin
          if (exp_tx.size() == 0) begin
            check("tx_unexpected", 32'(tx_byte), 32'h100);
          end else begin
            b = exp_tx.pop_front();
            check("tx_byte", 32'(tx_byte), 32'(b));
          end
        end
        held = tx_valid && !tx_ready;
        held_byte = tx_byte;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_byte = b;
    rx_valid = 1'b1;
    @(negedge CLK);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic wr, input logic [15:0] addr, input logic [31:0] data);
    cmd_t c;
    c.wr = wr;
    c.addr = addr;
    c.data = data;
    exp_cmd.push_back(c);
    send_byte(wr ? 8'h57 : 8'h52);
    send_byte(addr[15:8]);
    send_byte(addr[7:0]);
    if (wr) begin
      send_byte(data[31:24]);
      send_byte(data[23:16]);
      send_byte(data[15:8]);
      send_byte(data[7:0]);
    end
    check("cmd_latency", 32'(cmd_valid), 32'd1);
  endtask

  task automatic respond(input logic [31:0] d);
    rsp_data = d;
    rsp_valid = 1'b1;
    @(negedge CLK);
    rsp_valid = 1'b0;
    check("tx_latency", 32'(tx_valid), 32'd1);
  endtask

  task automatic push_word(input logic [31:0] d);
    exp_tx.push_back(d[31:24]);
    exp_tx.push_back(d[23:16]);
    exp_tx.push_back(d[15:8]);
    exp_tx.push_back(d[7:0]);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check("idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_byte", 32'(tx_byte), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_cmd_addr", 32'(cmd_addr), 32'd0);
    check("rst_cmd_data", cmd_data, 32'd0);

    // Write frame.
    exp_tx.push_back(8'h4B);
    send_frame(1'b1, 16'h0003, 32'hDEADBEEF);
    @(negedge CLK);
    respond(32'h0);
    wait_idle(50);

    // Read frame.
    push_word(32'h12345678);
    send_frame(1'b0, 16'hA010, 32'h0);
    @(negedge CLK);
    respond(32'h12345678);
    wait_idle(50);

    // Bad opcode, then a normal read.
    exp_tx.push_back(8'h45);
    send_byte(8'h33);
    wait_idle(50);
    push_word(32'hCAFEF00D);
    send_frame(1'b0, 16'hA011, 32'h0);
    @(negedge CLK);
    respond(32'hCAFEF00D);
    wait_idle(50);

    // Stray rsp_valid in IDLE is ignored.
    rsp_data = 32'h11111111;
    rsp_valid = 1'b1;
    @(negedge CLK);
    rsp_valid = 1'b0;
    @(negedge CLK);
    check("stray_rsp_busy", 32'(busy), 32'd0);
    check("stray_rsp_tx", 32'(tx_valid), 32'd0);

    // Inter-byte timeout after 57 00: still busy on the last allowed cycle, idle after.
    send_byte(8'h57);
    send_byte(8'h00);
    repeat (BT - 1) @(negedge CLK);
    check("ib_before_expiry", 32'(busy), 32'd1);
    @(negedge CLK);
    check("ib_expired", 32'(busy), 32'd0);

    // Byte arriving on the expiry cycle is dropped.
    send_byte(8'h57);
    repeat (BT - 1) @(negedge CLK);
    send_byte(8'h01);
    check("ib_tie_drop", 32'(busy), 32'd0);

    // Response timeout.
    exp_tx.push_back(8'h54);
    send_frame(1'b0, 16'h1234, 32'h0);
    n = 0;
    while (!tx_valid && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check("rsp_timeout_lat", 32'(n), 32'(RT + 1));
    wait_idle(50);

    // rsp_valid on the timeout cycle wins.
    push_word(32'hABCDEF01);
    send_frame(1'b0, 16'h2222, 32'h0);
    repeat (RT) @(negedge CLK);
    respond(32'hABCDEF01);
    wait_idle(50);

    // Backpressure on a 4-byte read reply.
    stall_en = 1'b1;
    push_word(32'h87654321);
    send_frame(1'b0, 16'hA0FF, 32'h0);
    @(negedge CLK);
    respond(32'h87654321);
    wait_idle(200);
    stall_en = 1'b0;

    // Reset mid-frame, then a fresh write frame.
    send_byte(8'h57);
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(8'hDE);
    RST = 1'b1;
    @(negedge CLK);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_cmd_addr", 32'(cmd_addr), 32'd0);
    check("mid_rst_cmd_data", cmd_data, 32'd0);
    check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    exp_tx.push_back(8'h4B);
    send_frame(1'b1, 16'hA004, 32'h01020304);
    @(negedge CLK);
    respond(32'h0);
    wait_idle(50);

    // RX bytes during a stalled SEND are dropped.
    stall_en = 1'b1;
    exp_tx.push_back(8'h4B);
    send_frame(1'b1, 16'h0005, 32'h55AA55AA);
    @(negedge CLK);
    respond(32'h0);
    send_byte(8'h52);
    send_byte(8'h00);
    send_byte(8'h01);
    wait_idle(100);
    stall_en = 1'b0;
    repeat (5) @(negedge CLK);
    check("drop_busy", 32'(busy), 32'd0);

    check("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
    check("cmd_queue_empty", 32'(exp_cmd.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
